// File: rtl/serial_add_ctrl.sv
// Bit-serial (nibble-serial) add/subtract controller: one shared 4-bit adder slice
// is stepped LSB-first across WIDTH bits, with valid/ready handshakes on both sides.
module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [3:0]         slice_a, slice_b;
  logic [4:0]         slice_sum;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case leaves one unassigned (no latches).
    slice_a   = a_q[4*idx_q +: 4];
    slice_b   = b_q[4*idx_q +: 4];
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_q};

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub | op_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[4*idx_q +: 4] = slice_sum[3:0];
        carry_d                = slice_sum[4];
        idx_d                  = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Signed overflow: operands agree in sign but the top sum bit does not.
          cout_d  = slice_sum[4];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all datapath registers, not just the state, are reset so an aborted op leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
    end
  end

  // Handshake flags decode straight from the state register; no input-to-output path.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed checks of serial_add_ctrl against an integer-arithmetic model.
module tb_serial_add_ctrl;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] op_a, op_b, result;
  logic         op_cin, op_sub, cout, ovf, busy;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, then range checks for carry and signed overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                output logic [W-1:0] r, output logic c, output logic o);
    longint ua, ub, sa, sb, u, s;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      u = ua - ub;
      s = sa - sb;
      c = (ua >= ub);
    end else begin
      u = ua + ub + longint'(cin);
      s = sa + sb + longint'(cin);
      c = (u >= (longint'(1) << W));
    end
    r = u[W-1:0];
    o = (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
  endfunction

  task automatic randomize_inputs();
    op_a   = W'($urandom);
    op_b   = W'($urandom);
    op_cin = 1'($urandom);
    op_sub = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    wait_idle();
    op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    randomize_inputs();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b in_ready=%b required busy=1 in_ready=0", busy, in_ready);
    end
  endtask

  task automatic wait_done();
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != NSLICE || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: %0d edges (out_valid=%b) required %0d", lat, out_valid, NSLICE);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] er, input logic ec, input logic eo);
    start_op(a, b, cin, sub);
    wait_done();
    checks++;
    if (result !== er || cout !== ec || ovf !== eo) begin
      errors++;
      $display("FAIL %s: result=%h cout=%b ovf=%b required result=%h cout=%b ovf=%b",
               name, result, cout, ovf, er, ec, eo);
    end
    finish_op();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      randomize_inputs();
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h cout=%b ovf=%b required 1 0 0 0000 0 0",
                 in_ready, out_valid, busy, result, cout, ovf);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op("plain_add",   16'h1234, 16'h0FF1, 1'b1, 1'b0, 16'h2226, 1'b0, 1'b0);
    run_op("full_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("subtract",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, er;
    logic cin, sub, ec, eo;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      model(a, b, cin, sub, er, ec, eo);
      run_op("random", a, b, cin, sub, er, ec, eo);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, er;
    logic ec, eo;
    a = W'($urandom); b = W'($urandom);
    model(a, b, 1'b0, 1'b1, er, ec, eo);
    start_op(a, b, 1'b0, 1'b1);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      randomize_inputs();
      @(posedge clk); #1;
      checks++;
      if (result !== er || cout !== ec || ovf !== eo || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure: result=%h cout=%b ovf=%b in_ready=%b out_valid=%b required %h %b %b 0 1",
                 result, cout, ovf, in_ready, out_valid, er, ec, eo);
      end
    end
    in_valid = 1'b0;
    finish_op();
    a = W'($urandom); b = W'($urandom);
    model(a, b, 1'b1, 1'b0, er, ec, eo);
    run_op("after_backpressure", a, b, 1'b1, 1'b0, er, ec, eo);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, er;
    logic ec, eo;
    start_op(16'h0102, 16'h0304, 1'b0, 1'b0);
    wait_done();
    checks++;
    if (result !== 16'h0406) begin
      errors++;
      $display("FAIL b2b_first: result=%h required 0406", result);
    end
    a = W'($urandom); b = W'($urandom);
    model(a, b, 1'b0, 1'b1, er, ec, eo);
    op_a = a; op_b = b; op_cin = 1'b0; op_sub = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: in_ready=%b busy=%b out_valid=%b required 1 0 0",
               in_ready, busy, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    randomize_inputs();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b required 1", busy);
    end
    wait_done();
    checks++;
    if (result !== er || cout !== ec || ovf !== eo) begin
      errors++;
      $display("FAIL b2b_second: result=%h cout=%b ovf=%b required %h %b %b",
               result, cout, ovf, er, ec, eo);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_run();
    start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: in_ready=%b out_valid=%b busy=%b result=%h cout=%b ovf=%b required 1 0 0 0000 0 0",
               in_ready, out_valid, busy, result, cout, ovf);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_valid: out_valid=%b required 0", out_valid);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < NSLICE + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL aborted_op_delivered: out_valid=%b required 0", out_valid);
      end
    end
    run_op("after_mid_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    randomize_inputs();
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencing controller that performs a WIDTH-bit add or subtract through a single shared 4-bit full_adder slice, one nibble per clock, least-significant first. The carry is registered between slices. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area when a wide adder is not affordable.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; NSLICE = WIDTH/4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  controller can accept an operand (high only in IDLE)
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- op_cin  in  1  carry-in for add; ignored when op_sub=1
- op_sub  in  1  1: compute A − B (A + ~B + 1)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference
- cout  out  1  carry-out of MSB slice (for subtract: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- busy  out  1  high in RUN or DONE

## Operation
- One clock and reset: clk and rst_n; rst_n is asynchronous and active-low.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a clock edge, latch op_a into a_reg and (op_sub ? ~op_b : op_b) into b_reg.
  - Set carry = op_sub ? 1 : op_cin and idx=0, then go to RUN.
- RUN:
  - The adder gets a_reg[4*idx+:4], b_reg[4*idx+:4] and carry.
  - On each edge, write sum into result[4*idx+:4], set carry to cout, and increment idx.
  - On the edge where idx==NSLICE−1, also register cout and ovf, and go to DONE.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), using bit 3 of the final slice.
- DONE:
  - out_valid=1; result, cout and ovf are held stable.
  - When out_ready=1 at an edge, go to IDLE.
- in_valid is ignored outside IDLE. Operands need only be stable on the accepting edge.
- result is written progressively during RUN. It is defined only while out_valid=1.
- Arithmetic is modulo 2^WIDTH. cout is the true carry out of bit WIDTH−1.
- WIDTH=4 (NSLICE=1): RUN lasts exactly one cycle.

## Timing
- Reset values:
  - state=IDLE, in_ready=1 (also while rst_n is low).
  - out_valid=0, busy=0, result=0, cout=0, ovf=0.
  - Internal a_reg, b_reg, carry and idx = 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No out_valid is produced and no partial result is delivered.
- Latency:
  - Accept at edge E0.
  - out_valid goes high after edge E0+NSLICE and is visible in the following cycle.
  - With WIDTH=16: accept at E0, out_valid high after E4.
- Throughput with out_ready held high: one operation per NSLICE+2 cycles (IDLE, NSLICE×RUN, DONE).
- Backpressure: DONE persists indefinitely. Outputs are frozen and in_ready=0.
- Simultaneous events:
  - The out_ready handshake and a new in_valid in the same DONE cycle do not accept the new request.
  - The new request is accepted at the next edge (in IDLE).
- in_ready, out_valid and busy decode directly from the state register. There is no combinational path from inputs to outputs.

## Test plan
- Reset:
  - Stimulus: hold rst_n low for 3 cycles with random inputs.
  - Required: in_ready=1, out_valid=0, busy=0, result=0x0000, cout=0, ovf=0. After release, the first op is accepted on the first edge with in_valid=1.
- Plain add, WIDTH=16:
  - Stimulus: A=0x1234, B=0x0FF1, cin=1, sub=0.
  - Required: result=0x2226, cout=0, ovf=0. out_valid is first seen after the 4th edge following accept.
- Full ripple carry:
  - Stimulus: A=0xFFFF, B=0x0000, cin=1.
  - Required: result=0x0000, cout=1, ovf=0.
- Subtract and overflow:
  - Stimulus: A=0x0005, B=0x0007, sub=1.
  - Required: result=0xFFFE, cout=0, ovf=0.
  - Stimulus: A=0x7FFF, B=0x0001, add with cin=0.
  - Required: result=0x8000, cout=0, ovf=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands.
  - Required: result, cout and ovf are stable; in_ready=0; the new operands are ignored. After out_ready=1, the controller returns to IDLE and the next op computes correctly.
- Reset mid-operation:
  - Stimulus: drive rst_n low during the 2nd RUN cycle of A=0xAAAA, B=0x5555, then issue A=0x0001, B=0x0001.
  - Required: the first op never raises out_valid; the second yields result=0x0002, cout=0.
